mm_tx_byte_out: RTL
===================

Name: mm_tx_byte_out

Overview:
- Byte-level transmit output stage of the MAC merge sublayer.
- Sits directly downstream of the Clause 99 transmit processing state machine (mod_99_5). It consumes its rTX_DATA / TX_MCRC / rTX_CPLT requests and returns rTXByteSent, mCRC_sent and data_complete_sent.
- Drives the byte stream to the RS (txd/tx_en) with PHY-side backpressure.
- Keeps a running CRC32 over preemptable fragment data and appends the 4-byte mCRC when a fragment is preempted.

Parameters:
- MCRC_XOR, 32'h0000FFFF, value XORed into the complemented CRC to form the mCRC.
- CRC_INIT, 32'hFFFFFFFF, CRC register seed.

Ports:
- clk  in  1  block clock
- reset_begin  in  1  asynchronous, active-high reset
- byte_valid  in  1  a byte is offered (rTX_DATA)
- byte_data  in  8  offered byte
- byte_crc_en  in  1  byte is preemptable fragment data and is included in the CRC
- byte_crc_init  in  1  reseed CRC before this byte (SMD-S/SMD-C, express bytes)
- byte_ready  out  1  holding register free; byte accepted when byte_valid&&byte_ready
- byte_sent  out  1  one-cycle pulse when a byte leaves on txd (rTXByteSent)
- mcrc_req  in  1  one-cycle pulse: emit mCRC, then end the fragment (TX_MCRC)
- mcrc_sent  out  1  one-cycle pulse after the 4th mCRC byte leaves
- cplt_req  in  1  one-cycle pulse: end current frame/fragment (rTX_CPLT)
- data_complete_sent  out  1  one-cycle pulse when tx_en has dropped after the last byte
- phy_ready  in  1  RS accepts a byte this cycle
- txd  out  8  byte to RS
- tx_en  out  1  txd valid / carrier

Behaviour:
- Reset values (asynchronous, active-high): all outputs 0 except byte_ready=1; crc=CRC_INIT; state=IDLE; holding register empty. Reset mid-frame aborts immediately; no partial mCRC completes.
- States are IDLE, DATA, MCRC, CPLT.
- IDLE:
  - tx_en=0.
  - An accepted byte loads the holding register and moves to DATA.
  - cplt_req in IDLE goes to CPLT; data_complete_sent follows next cycle.
  - mcrc_req in IDLE is ignored.
- DATA:
  - Holding register drives txd, tx_en=1.
  - On phy_ready, the byte is consumed and byte_sent pulses in that same cycle.
  - byte_ready=1 when the register is empty, or is being consumed this cycle (zero-bubble back-to-back).
  - Latency from accept to txd is 1 clk.
  - CRC update happens at consume time:
    - if crc_init: crc = step(CRC_INIT, d) when crc_en, else crc = CRC_INIT;
    - else if crc_en: crc = step(crc, d);
    - otherwise crc is unchanged.
  - tx_en stays 1 while the register is empty mid-frame, but txd must not be re-sent. An underrun leaves tx_en=1 and holds txd at its last value; underrun is an upstream error and must not occur.
- mcrc_req (DATA):
  - Sampled when the register is empty or is being consumed; byte_ready then drops.
  - If a byte is still pending, it is sent first; mcrc_req is latched.
  - Go to MCRC with value M = ~crc ^ MCRC_XOR, crc taken after the last data byte.
- MCRC:
  - Sends M[7:0], M[15:8], M[23:16], M[31:24], one per phy_ready, using a 2-bit counter.
  - byte_sent pulses for each of the 4 bytes.
  - mcrc_sent pulses in the cycle the 4th byte is consumed; then go to CPLT.
- cplt_req (DATA):
  - Latched; taken once the register is empty. A byte already pending is sent first.
  - No CRC is appended, because the final FCS is part of the pMAC data.
- CPLT:
  - tx_en=0 for one cycle, then data_complete_sent pulses one cycle, then IDLE.
  - byte_ready=0 throughout.
- Simultaneous requests:
  - mcrc_req and cplt_req in the same cycle: mcrc_req wins and cplt_req is dropped, because mod_99_5 issues rTX_CPLT only after mCRC_sent.
  - byte_valid together with mcrc_req/cplt_req: the byte is accepted and sent before the mCRC/end.
- CRC step: reflected CRC32, polynomial 0xEDB88320, LSB-first, 8 bits per step.

Decomposition:
- Shared package mm_tx_pkg holds:
  - state encoding constants (IDLE/DATA/MCRC/CPLT);
  - CRC_POLY_REFL = 32'hEDB88320;
  - MCRC_XOR default;
  - PREAMBLE byte 8'h55 and the SMD constants, for bench use.
- One sub-module: mm_crc32_step, combinational (crc_in[31:0], data[7:0]) -> crc_out[31:0]. It is used once in the datapath and also instantiated by the bench.

Test Plan:
- Express frame, byte_crc_en=0: 8 bytes with phy_ready=1, then cplt_req.
  - Required: txd sequence equal to the input bytes, tx_en high for exactly 8 cycles.
  - Required: 8 byte_sent pulses, then tx_en low for 1 cycle, then data_complete_sent 1 cycle later.
- mCRC golden value: byte_crc_init on the SMD byte (crc_en=0), then ASCII "123456789" with crc_en=1, then mcrc_req.
  - Required: mCRC bytes D9 C6 F4 CB in that order (FCS 0xCBF43926 XOR 0x0000FFFF).
  - Required: mcrc_sent on the D9…CB 4th byte, then data_complete_sent.
- Backpressure: phy_ready toggles 1,0,0,1,… during data and mCRC.
  - Required: no byte duplicated or lost.
  - Required: byte_sent only on phy_ready cycles.
  - Required: mCRC bytes stall correctly.
- Back-to-back fragments: after data_complete_sent, a new byte_crc_init byte (SMD-C) plus "123456789".
  - Required: the second mCRC is again D9 C6 F4 CB, proving reseed.
- Reset mid-mCRC: assert reset_begin after the 2nd mCRC byte.
  - Required: tx_en=0, byte_ready=1, no mcrc_sent, crc=FFFFFFFF.
  - Required: the next frame is correct.
- Simultaneous: byte_valid with mcrc_req in the same cycle.
  - Required: the byte is sent, then 4 mCRC bytes that include that byte in the CRC.
  - Required: cplt_req pulsed together with mcrc_req is ignored, and only one data_complete_sent occurs.

Source files
------------

// File: rtl/mm_tx_pkg.sv
// rtl/mm_tx_pkg.sv - shared types and constants for the MAC merge transmit byte stage
package mm_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_MCRC = 2'd2,
        ST_CPLT = 2'd3
    } tx_state_t;

    localparam logic [31:0] CRC_POLY_REFL    = 32'hEDB88320;
    localparam logic [31:0] MCRC_XOR_DEFAULT = 32'h0000FFFF;
    localparam logic [31:0] CRC_INIT_DEFAULT = 32'hFFFFFFFF;

    localparam logic [7:0] PREAMBLE = 8'h55;
    localparam logic [7:0] SMD_E    = 8'hD5;
    localparam logic [7:0] SMD_S0   = 8'hE6;
    localparam logic [7:0] SMD_S1   = 8'h4C;
    localparam logic [7:0] SMD_S2   = 8'h7F;
    localparam logic [7:0] SMD_S3   = 8'hB3;
    localparam logic [7:0] SMD_C0   = 8'h61;
    localparam logic [7:0] SMD_C1   = 8'h52;
    localparam logic [7:0] SMD_C2   = 8'h2A;
    localparam logic [7:0] SMD_C3   = 8'h9E;

    // mCRC goes out least significant byte first
    function automatic logic [7:0] mcrc_byte(input logic [31:0] m, input logic [1:0] idx);
        logic [31:0] s;
        s = m >> {idx, 3'b000};
        return s[7:0];
    endfunction

endpackage

// File: rtl/mm_tx_byte_out_if.sv
// rtl/mm_tx_byte_out_if.sv - request/response and RS-side signals of the transmit byte stage
interface mm_tx_byte_out_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_crc_en;
    logic       byte_crc_init;
    logic       byte_ready;
    logic       byte_sent;
    logic       mcrc_req;
    logic       mcrc_sent;
    logic       cplt_req;
    logic       data_complete_sent;
    logic       phy_ready;
    logic [7:0] txd;
    logic       tx_en;

    modport slave (
        input  byte_valid, byte_data, byte_crc_en, byte_crc_init, mcrc_req, cplt_req, phy_ready,
        output byte_ready, byte_sent, mcrc_sent, data_complete_sent, txd, tx_en
    );

    modport master (
        output byte_valid, byte_data, byte_crc_en, byte_crc_init, mcrc_req, cplt_req, phy_ready,
        input  byte_ready, byte_sent, mcrc_sent, data_complete_sent, txd, tx_en
    );
endinterface

// File: rtl/mm_crc32_step.sv
// rtl/mm_crc32_step.sv - one byte of reflected CRC32, LSB first
module mm_crc32_step
    import mm_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/mm_tx_byte_out.sv
// rtl/mm_tx_byte_out.sv - byte output stage: holding register, running CRC, mCRC append, frame end
module mm_tx_byte_out
    import mm_tx_pkg::*;
#(
    parameter logic [31:0] MCRC_XOR = MCRC_XOR_DEFAULT,
    parameter logic [31:0] CRC_INIT = CRC_INIT_DEFAULT
)(
    input  logic            clk,
    input  logic            reset_begin,
    mm_tx_byte_out_if.slave bus
);

    tx_state_t   state;
    logic        hold_full;
    logic [7:0]  hold_data;
    logic        hold_crc_en;
    logic        hold_crc_init;
    logic [31:0] crc;
    logic [31:0] mcrc_val;
    logic [1:0]  mcrc_cnt;
    logic        mcrc_pend;
    logic        cplt_pend;
    logic        cplt_phase;
    logic        dcs_q;

    logic [31:0] crc_base;
    logic [31:0] crc_step_out;
    logic [31:0] crc_next;
    logic        consume;
    logic        ready_c;
    logic        load;
    logic        empty_next;
    logic        want_mcrc;
    logic        want_cplt;

    assign crc_base = hold_crc_init ? CRC_INIT : crc;

    mm_crc32_step u_step (
        .crc_in  (crc_base),
        .data    (hold_data),
        .crc_out (crc_step_out)
    );

    // Once an end request is pending no further bytes are taken
    assign consume    = (state == ST_DATA) && hold_full && bus.phy_ready;
    assign ready_c    = (state == ST_IDLE) ||
                        ((state == ST_DATA) && (!hold_full || consume) && !mcrc_pend && !cplt_pend);
    assign load       = bus.byte_valid && ready_c;
    assign empty_next = (!hold_full || consume) && !load;
    assign want_mcrc  = mcrc_pend || bus.mcrc_req;
    assign want_cplt  = (cplt_pend || bus.cplt_req) && !want_mcrc;

    always_comb begin
        crc_next = crc;
        if (consume) begin
            if (hold_crc_init) begin
                crc_next = hold_crc_en ? crc_step_out : CRC_INIT;
            end else if (hold_crc_en) begin
                crc_next = crc_step_out;
            end
        end
    end

    assign bus.byte_ready         = ready_c;
    assign bus.byte_sent          = consume || ((state == ST_MCRC) && bus.phy_ready);
    assign bus.mcrc_sent          = (state == ST_MCRC) && bus.phy_ready && (mcrc_cnt == 2'd3);
    assign bus.tx_en              = (state == ST_DATA) || (state == ST_MCRC);
    assign bus.txd                = (state == ST_DATA) ? hold_data :
                                    (state == ST_MCRC) ? mcrc_byte(mcrc_val, mcrc_cnt) : 8'h00;
    assign bus.data_complete_sent = dcs_q;

    always_ff @(posedge clk or posedge reset_begin) begin
        if (reset_begin) begin
            state         <= ST_IDLE;
            hold_full     <= 1'b0;
            hold_data     <= 8'h00;
            hold_crc_en   <= 1'b0;
            hold_crc_init <= 1'b0;
            crc           <= CRC_INIT;
            mcrc_val      <= 32'h0;
            mcrc_cnt      <= 2'd0;
            mcrc_pend     <= 1'b0;
            cplt_pend     <= 1'b0;
            cplt_phase    <= 1'b0;
            dcs_q         <= 1'b0;
        end else begin
            dcs_q <= 1'b0;
            crc   <= crc_next;

            if (load) begin
                hold_data     <= bus.byte_data;
                hold_crc_en   <= bus.byte_crc_en;
                hold_crc_init <= bus.byte_crc_init;
                hold_full     <= 1'b1;
            end else if (consume) begin
                hold_full <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state     <= ST_DATA;
                        mcrc_pend <= bus.mcrc_req;
                        cplt_pend <= bus.cplt_req && !bus.mcrc_req;
                    end else if (bus.cplt_req) begin
                        state      <= ST_CPLT;
                        cplt_phase <= 1'b0;
                    end
                end
                ST_DATA: begin
                    // mCRC covers every byte up to and including the one leaving now
                    if (want_mcrc && empty_next) begin
                        state     <= ST_MCRC;
                        mcrc_val  <= ~crc_next ^ MCRC_XOR;
                        mcrc_cnt  <= 2'd0;
                        mcrc_pend <= 1'b0;
                        cplt_pend <= 1'b0;
                    end else if (want_cplt && empty_next) begin
                        state      <= ST_CPLT;
                        cplt_phase <= 1'b0;
                        mcrc_pend  <= 1'b0;
                        cplt_pend  <= 1'b0;
                    end else begin
                        mcrc_pend <= want_mcrc;
                        cplt_pend <= want_cplt;
                    end
                end
                ST_MCRC: begin
                    if (bus.phy_ready) begin
                        mcrc_cnt <= mcrc_cnt + 2'd1;
                        if (mcrc_cnt == 2'd3) begin
                            state      <= ST_CPLT;
                            cplt_phase <= 1'b0;
                        end
                    end
                end
                ST_CPLT: begin
                    if (!cplt_phase) begin
                        cplt_phase <= 1'b1;
                        dcs_q      <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
